// File: rtl/alu_exec_if.sv
// Request/response bundle between a requester and alu_exec_unit.
// The requester drives the operation; the unit returns a registered result.
interface alu_exec_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [9:0]      funct_i;
  logic [1:0]      ALUOp_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [XLEN-1:0] result_o;
  logic            valid_o;
  logic            zero_o;

  modport master (
    output valid_i, funct_i, ALUOp_i, a_i, b_i,
    input  ready_o, result_o, valid_o, zero_o
  );

  modport slave (
    input  valid_i, funct_i, ALUOp_i, a_i, b_i,
    output ready_o, result_o, valid_o, zero_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered ALU: decodes {funct7, funct3, ALUOp} and returns a result under valid/ready.
// MUL is either single-cycle or a fixed-latency radix-2 shift-add over XLEN cycles.
module alu_exec_unit #(
  parameter int unsigned XLEN    = 32,
  parameter bit          MUL_SEQ = 1'b1
) (
  input logic       clk_i,
  input logic       rst_i,
  alu_exec_if.slave bus
);
  localparam int unsigned ShW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpMul
  } op_e;

  typedef enum logic {StIdle, StMul} state_e;

  state_e          state_q;
  op_e             op;
  logic [5:0]      key;
  logic [ShW-1:0]  shamt;
  logic [ShW-1:0]  cnt_q;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_d;
  logic            valid_q;
  logic            zero_q;
  logic            unused_funct;

  assign key          = {bus.funct_i[8], bus.funct_i[3], bus.funct_i[2:0], bus.ALUOp_i[0]};
  assign shamt        = bus.b_i[ShW-1:0];
  assign unused_funct = ^{bus.funct_i[9], bus.funct_i[7:4], bus.ALUOp_i[1]};

  always_comb begin
    op = OpAdd;
    case (key)
      6'b001111: op = OpAnd;
      6'b001001: op = OpXor;
      6'b001101: op = OpOr;
      6'b000011: op = OpSll;
      6'b000101: op = OpSrl;
      6'b101010: op = OpSra;
      6'b100001: op = OpSub;
      6'b010001: op = OpMul;
      default:   op = OpAdd;
    endcase
  end

  always_comb begin
    alu_res = bus.a_i + bus.b_i;
    case (op)
      OpSub:   alu_res = bus.a_i - bus.b_i;
      OpAnd:   alu_res = bus.a_i & bus.b_i;
      OpOr:    alu_res = bus.a_i | bus.b_i;
      OpXor:   alu_res = bus.a_i ^ bus.b_i;
      OpSll:   alu_res = bus.a_i << shamt;
      OpSrl:   alu_res = bus.a_i >> shamt;
      OpSra:   alu_res = $signed(bus.a_i) >>> shamt;
      // The sequential build never uses this path, so keep the array multiplier out of it.
      OpMul:   alu_res = MUL_SEQ ? '0 : bus.a_i * bus.b_i;
      default: alu_res = bus.a_i + bus.b_i;
    endcase
  end

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.valid_i) begin
            if (MUL_SEQ && op == OpMul) begin
              mcand_q  <= bus.a_i;
              mplier_q <= bus.b_i;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StMul;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              valid_q  <= 1'b1;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // No early exit on a zero multiplier: latency stays fixed at XLEN.
          if (cnt_q == ShW'(XLEN - 1)) begin
            result_q <= acc_d;
            zero_q   <= (acc_d == '0);
            valid_q  <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready_o  = (state_q == StIdle);
  assign bus.result_o = result_q;
  assign bus.valid_o  = valid_q;
  assign bus.zero_o   = zero_q;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, registered successor to the combinational ALU-control decoder.
- Decodes {funct7, funct3} plus ALUOp into an operation and executes it on XLEN-bit operands.
- Returns a registered result under a valid/ready handshake.
- Single-cycle ops complete in 1 cycle. MUL is either an iterative shift-add (XLEN cycles) or single-cycle, per parameter; pipeline stalls on ready_o.

Parameters:
- XLEN, 32, operand/result width (≥4, power of 2).
- MUL_SEQ, 1, 1 = iterative radix-2 multiplier; 0 = single-cycle multiply.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept a request this cycle.
- funct_i  in  10  {funct7[6:0], funct3[2:0]}.
- ALUOp_i  in  2  main-control op class; only bit 0 is decoded.
- a_i  in  XLEN  operand A (rs1).
- b_i  in  XLEN  operand B (rs2 or pre-selected immediate).
- result_o  out  XLEN  registered result.
- valid_o  out  1  one-cycle pulse; result_o valid.
- zero_o  out  1  registered (result == 0), updated with result_o.

Behaviour:
- Decode key = {funct_i[8], funct_i[3], funct_i[2:0], ALUOp_i[0]}:
  - 001111 AND; 001001 XOR; 000011 SLL; 000001 ADD; 100001 SUB; 010001 MUL; 101010 SRAI.
  - New: 001101 OR; 000101 SRL.
  - Any other key: ADDI (a_i + b_i).
- Arithmetic:
  - ADD/ADDI/SUB wrap modulo 2^XLEN.
  - MUL returns the low XLEN bits of a_i*b_i; identical for signed and unsigned.
  - Shift amount = b_i[log2(XLEN)-1:0]; upper bits are ignored.
  - SRAI replicates a_i[XLEN-1]; SRL and SLL zero-fill.
- Reset (asynchronous, any time, including mid-MUL):
  - state=IDLE, result_o=0, zero_o=1, valid_o=0, ready_o=1.
  - Iteration counter and partial product cleared; in-flight op discarded, no valid_o.
- FSM states: IDLE, MUL.
  - ready_o = (state == IDLE), combinational from state only.
  - IDLE with valid_i=0: hold. result_o and zero_o keep their last values; valid_o=0.
  - IDLE with valid_i=1 and a non-MUL op (or MUL with MUL_SEQ=0): at that edge, register result and zero_o; valid_o=1 the following cycle; stay IDLE.
  - Back-to-back requests accepted every cycle (throughput 1).
  - IDLE with valid_i=1, MUL, MUL_SEQ=1: at that edge, latch multiplicand=a_i, multiplier=b_i, acc=0, cnt=0; go to MUL. valid_o=0 next cycle.
  - MUL, each edge: if multiplier[0], acc += multiplicand (mod 2^XLEN); multiplicand <<= 1; multiplier >>= 1; cnt++.
  - MUL, on the edge where cnt reaches XLEN-1 → IDLE: result_o=final acc, zero_o updated, valid_o=1 the following cycle.
  - Total: acceptance edge E0, valid_o high in the cycle after edge E0+XLEN, together with ready_o=1.
- Inputs sampled only on an accepting edge (valid_i && ready_o). During MUL, valid_i/funct_i/a_i/b_i are ignored; the requester must hold its request.
- valid_o is high exactly one cycle per completed op, never two ops' worth in one cycle.
- No early termination on a zero multiplier: MUL latency is fixed at XLEN cycles for deterministic timing.

Test Plan:
- Reset: assert rst_i asynchronously between edges → immediately result_o=0, zero_o=1, valid_o=0, ready_o=1.
- Decode sweep, XLEN=32, a=0xF0F0_000F, b=0x0000_0004, one op per cycle:
  - AND=0x4, XOR=0xF0F0_000B, OR=0xF0F0_000F, ADD=0xF0F0_0013, SUB=0xF0F0_000B, SLL=0x0F00_00F0, SRL=0x0F0F_0000, SRAI=0xFF0F_0000.
  - Each result has valid_o one cycle later; ready_o stays 1 throughout.
- Default decode: key 111110 → ADDI. a=0xFFFF_FFFF, b=1 → result 0, zero_o=1 (wrap).
- Sequential MUL (MUL_SEQ=1): a=7, b=0xFFFF_FFFD (-3) → ready_o low for 32 cycles; valid_o in the cycle after E0+32; result 0xFFFF_FFEB.
  - A valid_i AND request held during MUL is accepted only once ready_o=1.
- Reset mid-MUL: assert rst_i at cnt=10 → IDLE, no valid_o pulse, result_o=0.
  - A following ADD 2+3 → 5 with normal latency 1.
- MUL_SEQ=0 instance: MUL 0x0001_0000*0x0001_0000 → result 0, zero_o=1, latency 1.
  - Back-to-back MUL/ADD accepted on consecutive edges.
